// File: rtl/alu_div_iter_pkg.sv
// Shared ALU configuration: default datapath width, divider FSM states and special results.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ALU_XLEN, div_state_e, div_cnt_w(), divide-by-zero / overflow result fill bits.
package alu_div_iter_pkg;

  localparam int ALU_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CORRECT,
    ST_DONE
  } div_state_e;

  // Iteration counter must hold XLEN+1 (full-width step count).
  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen + 2);
  endfunction

  // Divide-by-zero quotient is all-ones; signed-overflow remainder is all-zeros.
  localparam logic DIV0_QUOT_BIT = 1'b1;
  localparam logic OVF_REM_BIT   = 1'b0;

endpackage

// File: rtl/alu_div_iter_if.sv
// Issue-side handshake bundle for the iterative divider (names are from the divider's view).
// Latency: n/a (wires only).
// Backpressure: in_valid_i/in_ready_o on the request side, out_valid_o/out_ready_i on the result side.
// Ports: flush_i, in_valid_i, in_ready_o, signed_i, word_i, dividend_i, divisor_i,
//        out_valid_o, out_ready_i, quot_o, rem_o. Modports: master (issue logic), slave (divider).
interface alu_div_iter_if
  import alu_div_iter_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            signed_i;
  logic            word_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] quot_o;
  logic [XLEN-1:0] rem_o;

  modport master (
    output flush_i, in_valid_i, signed_i, word_i, dividend_i, divisor_i, out_ready_i,
    input  in_ready_o, out_valid_o, quot_o, rem_o
  );

  modport slave (
    input  flush_i, in_valid_i, signed_i, word_i, dividend_i, divisor_i, out_ready_i,
    output in_ready_o, out_valid_o, quot_o, rem_o
  );
endinterface

// File: rtl/alu_div_nr_step.sv
// One radix-2 non-restoring division step on a (2*WIDTH+2)-bit partial remainder.
// Latency: combinational.
// Backpressure: none.
// Ports: pr_i partial remainder, d_i divisor, nd_i negated divisor (WIDTH+1 bits each);
//        pr_o next partial remainder (already shifted left), q_o quotient bit.
module alu_div_nr_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH+1:0] pr_i,
  input  logic [WIDTH:0]     d_i,
  input  logic [WIDTH:0]     nd_i,
  output logic [2*WIDTH+1:0] pr_o,
  output logic               q_o
);
  logic [WIDTH:0]   src;
  logic [2*WIDTH:0] addend;
  logic [2*WIDTH:0] sum;

  // Same signs -> subtract (q=1), different -> add (q=0). Zero counts as positive.
  assign q_o    = (pr_i[2*WIDTH+1] == d_i[WIDTH]);
  assign src    = q_o ? nd_i : d_i;
  // Divisor is aligned to bit WIDTH; the top bit of the sum is discarded by the shift.
  assign addend = {src, {WIDTH{1'b0}}};
  assign sum    = pr_i[2*WIDTH:0] + addend;
  assign pr_o   = {sum, 1'b0};
endmodule

// File: rtl/alu_div_iter.sv
// Iterative signed/unsigned radix-2 non-restoring divider with word mode and RISC-V special results.
// Latency: W+3 cycles from accept to out_valid_o (W = XLEN or XLEN/2); 1 cycle for div-by-zero/overflow.
// Backpressure: result held in DONE until out_ready_i; in_ready_o only in IDLE; flush_i aborts at any time.
// Ports: clk, rst (sync, active-high), div_if (slave modport of alu_div_iter_if).
module alu_div_iter
  import alu_div_iter_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic          clk,
  input  logic          rst,
  alu_div_iter_if.slave div_if
);
  localparam int H     = XLEN / 2;
  localparam int CNT_W = div_cnt_w(XLEN);
  localparam logic [CNT_W-1:0] ITER_FULL = CNT_W'(XLEN + 1);
  localparam logic [CNT_W-1:0] ITER_WORD = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [XLEN-1:0]  Q_ONE     = {{(XLEN-1){1'b0}}, 1'b1};

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN+1:0] pr_q, pr_d, pr_step;
  logic [XLEN-2:0]   quo_q, quo_d;
  logic [XLEN:0]     d_q, d_d, nd_q, nd_d;
  logic              a_neg_q, a_neg_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic              out_valid_q, out_valid_d;
  logic              q_bit;

  // Operand preparation (combinational view of the inputs at accept time)
  logic [H-1:0]      dvd_lo, dvs_lo;
  logic              a_neg, d_neg;
  logic [XLEN:0]     a_ext, d_ext;
  logic [2*XLEN+1:0] pr_init;
  logic [XLEN-1:0]   dvd_w;
  logic              div_zero, ovf;
  logic              in_ready, accept;

  // Correction
  logic [XLEN:0]     r_raw;
  logic [XLEN-1:0]   r_fix, q_raw, q_fix;

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = div_if.in_valid_i && in_ready && !div_if.flush_i;

  always_comb begin
    dvd_lo = div_if.dividend_i[H-1:0];
    dvs_lo = div_if.divisor_i[H-1:0];
    a_neg  = div_if.signed_i & (div_if.word_i ? dvd_lo[H-1] : div_if.dividend_i[XLEN-1]);
    d_neg  = div_if.signed_i & (div_if.word_i ? dvs_lo[H-1] : div_if.divisor_i[XLEN-1]);
    a_ext  = div_if.word_i ? {{(XLEN+1-H){a_neg}}, dvd_lo} : {a_neg, div_if.dividend_i};
    d_ext  = div_if.word_i ? {{(XLEN+1-H){d_neg}}, dvs_lo} : {d_neg, div_if.divisor_i};
    // Word operands start pre-shifted by H so the shared datapath needs only H+1 steps and
    // the final remainder lands in the same upper slice as in full-width mode.
    pr_init = div_if.word_i ? {{(XLEN+1-H){a_neg}}, a_ext, {H{1'b0}}}
                            : {{(XLEN+1){a_neg}}, a_ext};
    dvd_w    = div_if.word_i ? {{(XLEN-H){dvd_lo[H-1]}}, dvd_lo} : div_if.dividend_i;
    div_zero = div_if.word_i ? (dvs_lo == '0) : (div_if.divisor_i == '0);
    ovf      = div_if.signed_i &
               (div_if.word_i ? ((dvd_lo == {1'b1, {(H-1){1'b0}}}) && (dvs_lo == '1))
                              : ((div_if.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                                 (div_if.divisor_i == '1)));
  end

  alu_div_nr_step #(.WIDTH(XLEN)) u_step (
    .pr_i (pr_q),
    .d_i  (d_q),
    .nd_i (nd_q),
    .pr_o (pr_step),
    .q_o  (q_bit)
  );

  // Quotient digits are +/-1; with P = collected q=1 bits, Q = 2P+1 mod 2^XLEN.
  always_comb begin
    r_raw = pr_q[2*XLEN+1:XLEN+1];
    q_raw = {quo_q, 1'b1};
    r_fix = r_raw[XLEN-1:0];
    q_fix = q_raw;
    if ((r_raw != '0) && (r_raw[XLEN] != a_neg_q)) begin
      // Remainder landed on the wrong side of zero: step one divisor back toward the dividend.
      if (r_raw[XLEN] == d_q[XLEN]) begin
        r_fix = r_raw[XLEN-1:0] + nd_q[XLEN-1:0];
        q_fix = q_raw + Q_ONE;
      end else begin
        r_fix = r_raw[XLEN-1:0] + d_q[XLEN-1:0];
        q_fix = q_raw - Q_ONE;
      end
    end else if (r_raw == d_q) begin
      r_fix = '0;
      q_fix = q_raw + Q_ONE;
    end else if (r_raw == nd_q) begin
      r_fix = '0;
      q_fix = q_raw - Q_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    d_d         = d_q;
    nd_d        = nd_q;
    a_neg_d     = a_neg_q;
    word_d      = word_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (div_zero || ovf) begin
            quot_d      = div_zero ? {XLEN{DIV0_QUOT_BIT}} : dvd_w;
            rem_d       = div_zero ? dvd_w : {XLEN{OVF_REM_BIT}};
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            pr_d    = pr_init;
            quo_d   = '0;
            d_d     = d_ext;
            nd_d    = -d_ext;
            a_neg_d = a_neg;
            word_d  = div_if.word_i;
            cnt_d   = div_if.word_i ? ITER_WORD : ITER_FULL;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        pr_d  = pr_step;
        quo_d = {quo_q[XLEN-3:0], q_bit};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        quot_d      = word_q ? {{(XLEN-H){q_fix[H-1]}}, q_fix[H-1:0]} : q_fix;
        rem_d       = word_q ? {{(XLEN-H){r_fix[H-1]}}, r_fix[H-1:0]} : r_fix;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (div_if.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (div_if.flush_i) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      d_q         <= '0;
      nd_q        <= '0;
      a_neg_q     <= 1'b0;
      word_q      <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      d_q         <= d_d;
      nd_q        <= nd_d;
      a_neg_q     <= a_neg_d;
      word_q      <= word_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign div_if.in_ready_o  = in_ready;
  assign div_if.out_valid_o = out_valid_q;
  assign div_if.quot_o      = quot_q;
  assign div_if.rem_o       = rem_q;
endmodule

// File: tb/tb_alu_div_iter.sv
// Directed bench for alu_div_iter at XLEN=64: arithmetic, latency, special results, backpressure, flush.
// Latency: n/a.
// Backpressure: out_ready_i driven by the bench.
module tb_alu_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  alu_div_iter_if #(.XLEN(64)) dif ();

  alu_div_iter #(.XLEN(64)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic wrd, input logic [63:0] a, input logic [63:0] b);
    chk_eq("in_ready before accept", 64'(dif.in_ready_o), 64'd1);
    dif.signed_i   = sgn;
    dif.word_i     = wrd;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    dif.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    // Operands are don't-care after accept; scramble them.
    dif.in_valid_i = 1'b0;
    dif.signed_i   = ~sgn;
    dif.word_i     = ~wrd;
    dif.dividend_i = {$urandom, $urandom};
    dif.divisor_i  = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!dif.out_valid_o && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic wrd,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int elat);
    int lat;
    start_op(sgn, wrd, a, b);
    wait_valid(lat);
    chk_eq({tag, " latency"}, 64'(lat), 64'(elat));
    chk_eq({tag, " quot"}, dif.quot_o, eq);
    chk_eq({tag, " rem"}, dif.rem_o, er);
    @(posedge clk);
    #1;
    chk_eq({tag, " valid drops after handshake"}, 64'(dif.out_valid_o), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [63:0] hq, hr;
    dif.flush_i     = 1'b0;
    dif.in_valid_i  = 1'b0;
    dif.signed_i    = 1'b0;
    dif.word_i      = 1'b0;
    dif.dividend_i  = '0;
    dif.divisor_i   = '0;
    dif.out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("in_ready in reset", 64'(dif.in_ready_o), 64'd0);
    chk_eq("out_valid in reset", 64'(dif.out_valid_o), 64'd0);
    rst = 1'b0;
    #1;
    chk_eq("quot after reset", dif.quot_o, 64'd0);
    chk_eq("rem after reset", dif.rem_o, 64'd0);
    chk_eq("in_ready after reset", 64'(dif.in_ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Full-width arithmetic
    run_div("u64 100/7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 67);
    run_div("u64 max/16", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
            64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 67);
    run_div("s64 -1/16", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
            64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 67);
    run_div("s64 -7/2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 67);
    run_div("s64 7/-2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 67);
    run_div("s64 -6/3", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 64'd3,
            64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 67);

    // Word mode
    run_div("w signed -7/2", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 35);
    run_div("w unsigned 0x80000000/1", 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
            64'hFFFF_FFFF_8000_0000, 64'd0, 35);
    run_div("w unsigned 100/7 upper junk", 1'b0, 1'b1, 64'hABCD_0000_0000_0064,
            64'hFFFF_FFFF_0000_0007, 64'd14, 64'd2, 35);

    // Special results
    run_div("div0 42/0", 1'b0, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
    run_div("w div0 5/0", 1'b0, 1'b1, 64'd5, 64'h0000_0001_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
    run_div("s64 overflow", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0, 1);
    run_div("w signed overflow", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 64'd0, 1);

    // Backpressure: result held stable while out_ready_i is low
    dif.out_ready_i = 1'b0;
    start_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_valid(lat);
    chk_eq("bp latency", 64'(lat), 64'd67);
    hq = 64'hFFFF_FFFF_FFFF_FFFD;
    hr = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_eq("bp out_valid held", 64'(dif.out_valid_o), 64'd1);
      chk_eq("bp in_ready low", 64'(dif.in_ready_o), 64'd0);
      chk_eq("bp quot stable", dif.quot_o, hq);
      chk_eq("bp rem stable", dif.rem_o, hr);
    end
    dif.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("bp release valid", 64'(dif.out_valid_o), 64'd0);
    chk_eq("bp release in_ready", 64'(dif.in_ready_o), 64'd1);

    // Flush during CALC iteration 20
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    chk_eq("mid-calc in_ready low", 64'(dif.in_ready_o), 64'd0);
    dif.flush_i = 1'b1;
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    chk_eq("flush to idle", 64'(dif.in_ready_o), 64'd1);
    chk_eq("flush out_valid", 64'(dif.out_valid_o), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (dif.out_valid_o) seen = 1;
    end
    chk_eq("flushed op never completes", 64'(seen), 64'd0);

    // Flush and in_valid together: a div-by-zero would show valid next cycle if accepted
    dif.flush_i    = 1'b1;
    dif.in_valid_i = 1'b1;
    dif.signed_i   = 1'b0;
    dif.word_i     = 1'b0;
    dif.dividend_i = 64'd42;
    dif.divisor_i  = 64'd0;
    @(posedge clk);
    #1;
    dif.flush_i    = 1'b0;
    dif.in_valid_i = 1'b0;
    chk_eq("flush+valid no accept valid", 64'(dif.out_valid_o), 64'd0);
    chk_eq("flush+valid still idle", 64'(dif.in_ready_o), 64'd1);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (dif.out_valid_o) seen = 1;
    end
    chk_eq("flush+valid never completes", 64'(seen), 64'd0);

    run_div("after flush 100/7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 67);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_div_iter.md
# alu_div_iter

Parametrised iterative radix-2 non-restoring divider for the execute stage's multi-cycle ALU path. It handles signed and unsigned operands, full-width and word (XLEN/2) modes, and RISC-V special results for divide-by-zero and signed overflow. It talks to the issue logic through valid/ready on both input and output, and a pipeline flush can abort it at any time.

## Interface
- `XLEN`, default 64: datapath width. Must be even and ≥ 8. Word mode operates on `XLEN/2`.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `flush_i` input 1: abort any in-flight operation.
- `in_valid_i` input 1: operands valid.
- `in_ready_o` output 1: divider can accept.
- `signed_i` input 1: signed (DIV/REM) vs unsigned (DIVU/REMU).
- `word_i` input 1: word mode, using the low `XLEN/2` bits of each operand.
- `dividend_i` input XLEN: dividend (rs1).
- `divisor_i` input XLEN: divisor (rs2).
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: consumer takes the result.
- `quot_o` output XLEN: quotient.
- `rem_o` output XLEN: remainder.

## Operation
- **States:**
  - IDLE: accept.
  - CALC: one non-restoring step per cycle.
  - CORRECT: final quotient/remainder fix-up.
  - DONE: hold result.
- **Accept:** `in_valid_i && in_ready_o` at a rising edge. Operands, `signed_i` and `word_i` are captured then; inputs are don't-care afterwards. `in_ready_o` = (state==IDLE) && !`rst`.
- **Operand prep:** W = `XLEN` or `XLEN/2`.
  - Sign bit is the operand MSB when `signed_i`, else 0.
  - Operands extend to W+1 bits; the partial remainder is 2W+2 bits.
  - The negated divisor is precomputed at accept.
- **Step rule:**
  - If the partial-remainder sign ≠ divisor sign, add the divisor and emit q-bit 0.
  - Otherwise, subtract and emit q-bit 1.
  - Shift left by one.
- **Correction:**
  - If the final remainder sign ≠ dividend sign and the remainder ≠ 0, adjust the remainder by ±d and the quotient by ∓1.
  - If the remainder equals ±d, zero it and fix the quotient (exact-division case).
  - Results match the truncating-toward-zero convention: the remainder takes the dividend's sign.
- **Special cases,** detected at accept, skip CALC/CORRECT and go straight to DONE:
  - Divisor 0 (in W bits): quotient all-ones, remainder = dividend (W bits).
  - Signed, dividend = most negative W-bit value, divisor = −1: quotient = dividend, remainder = 0.
- **Word mode:** both outputs are sign-extended from bit W−1 to `XLEN`, in signed and unsigned modes alike (RV64 *W semantics).
- **DONE:**
  - `out_valid_o`=1; outputs stable until `out_valid_o && out_ready_i`, then IDLE.
  - No accept in the same cycle as output handoff.
- **Flush:**
  - `flush_i` high at an edge moves any state to IDLE and drops `out_valid_o`; the in-flight result is discarded.
  - Flush beats `in_valid_i` in the same cycle; nothing is accepted.
- **Reset:** state IDLE; `out_valid_o`=0, `quot_o`=0, `rem_o`=0, iteration counter 0. Reset mid-operation discards it identically to flush.

## Timing
- **Normal op,** accept edge at cycle 0:
  - CALC during cycles 1..W+1 (W+1 iterations).
  - CORRECT at cycle W+2.
  - `out_valid_o` first high in cycle W+3.
  - This gives 67 cycles for XLEN=64 full width and 35 for word mode.
- **Special case:** `out_valid_o` high in cycle 1.
- **Throughput:** the next accept is no earlier than the cycle after the output handshake.
- **Registered outputs:** `quot_o`, `rem_o` and `out_valid_o` are registered. `in_ready_o` is combinational from state and `rst` only.

## Structure
- **Shared header:** state encodings, the iteration-counter width ($clog2(XLEN+2)), and the special-result constants go in the shared ALU config header next to `XLEN`.
- **Sub-module `alu_div_nr_step`,** parameter WIDTH: combinational single step. Inputs are the partial remainder, d and −d; outputs are the next partial remainder and the q-bit.
- **Datapath instancing:** one instance sized for `XLEN`. Word mode uses its low slice.

## Test plan
All scenarios use XLEN=64.
- **Unsigned 64:** 100/7 → q=14, r=2. `out_valid_o` rises exactly 67 cycles after accept.
- **Signed 64:**
  - −7/2 → q=0xFFFF_FFFF_FFFF_FFFD, r=0xFFFF_FFFF_FFFF_FFFF.
  - 7/−2 → q=−3, r=1.
  - −6/3 → q=−2, r=0 (exact-division correction).
- **Word mode:**
  - Signed 0x0000_0000_FFFF_FFF9 / 2 → q=0xFFFF_FFFF_FFFF_FFFD, r=−1, latency 35.
  - Unsigned 0x8000_0000 / 1 → q=0xFFFF_FFFF_8000_0000.
- **Divide-by-zero:**
  - 42/0 → q=0xFFFF_FFFF_FFFF_FFFF, r=42, `out_valid_o` in cycle 1.
  - Word unsigned 5/0 → q=all-ones, r=5.
- **Overflow:**
  - Signed 0x8000_0000_0000_0000 / −1 → q=0x8000_0000_0000_0000, r=0.
  - Word signed 0x8000_0000 / −1 → q=0xFFFF_FFFF_8000_0000, r=0.
- **Backpressure and flush:**
  - Hold `out_ready_i`=0 for 10 cycles → outputs stable and `in_ready_o`=0.
  - Flush at CALC iteration 20 → IDLE next cycle and `out_valid_o` never rises.
  - Flush with `in_valid_i` the same cycle → no accept.
  - The following op (100/7) → correct result.
